// File: rtl/spi_slave_ctrl.sv
// -----------------------------------------------------------------------------
// spi_slave_ctrl
//
// SPI mode-0 slave frame controller. SCK, CS_N and MOSI are oversampled in the
// clk domain. Each CS_N-low frame is one command byte followed by data bytes:
//   cmd[7]          : 1 = read burst, 0 = write burst
//   cmd[ADDR_W-1:0] : start address (auto-increments per data byte)
// The register bank is driven through a simple single-cycle port.
//
// Ports:
//   clk        system clock, all logic on rising edge
//   rst_n      asynchronous active-low reset
//   sck        SPI clock from master (asynchronous)
//   cs_n       SPI chip select, active low (asynchronous)
//   mosi       SPI data from master (asynchronous)
//   miso       SPI data to master (MSB first)
//   miso_oe    miso drive enable, high while the synchronized CS is active
//   reg_addr   register address
//   reg_wdata  register write data
//   reg_wr     one-cycle write strobe
//   reg_rd     one-cycle read strobe
//   reg_rdata  register read data, valid exactly one clk after reg_rd
//   busy       synchronized CS active
//   frame_err  one-cycle pulse when a frame ends on a partial byte
// -----------------------------------------------------------------------------
module spi_slave_ctrl #(
    parameter int ADDR_W      = 7,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sck,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [7:0]        reg_wdata,
    output logic              reg_wr,
    output logic              reg_rd,
    input  logic [7:0]        reg_rdata,
    output logic              busy,
    output logic              frame_err
);

    // -------------------------------------------------------------------------
    // Frame state machine encoding
    // -------------------------------------------------------------------------
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CMD      = 3'd1,
        ST_WDATA    = 3'd2,
        ST_RD_ISSUE = 3'd3,
        ST_RD_LOAD  = 3'd4,
        ST_RDATA    = 3'd5
    } state_t;

    state_t state_q, state_d;

    // -------------------------------------------------------------------------
    // Input synchronizers
    // -------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sck_sync_q,  sck_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q,   cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;

    // Tracks how far real pin samples have propagated since reset release.
    // The CS synchronizer resets to "deasserted", so without this a CS_N that
    // is already low at reset release would look like a fresh falling edge.
    // Bit SYNC_STAGES set means cs_prev_q holds a genuine sample.
    logic [SYNC_STAGES:0]   sync_vld_q,  sync_vld_d;

    logic sck_prev_q, sck_prev_d;
    logic cs_prev_q,  cs_prev_d;

    logic sck_s;
    logic cs_s;
    logic mosi_s;

    always_comb begin
        sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0],  sck};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0],   cs_n};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        sync_vld_d  = {sync_vld_q[SYNC_STAGES-1:0],  1'b1};
        sck_prev_d  = sck_s;
        cs_prev_d   = cs_s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync_q  <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sync_vld_q  <= '0;
            sck_prev_q  <= 1'b0;
            cs_prev_q   <= 1'b1;
        end else begin
            sck_sync_q  <= sck_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sync_vld_q  <= sync_vld_d;
            sck_prev_q  <= sck_prev_d;
            cs_prev_q   <= cs_prev_d;
        end
    end

    assign sck_s  = sck_sync_q[SYNC_STAGES-1];
    assign cs_s   = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    // -------------------------------------------------------------------------
    // Edge detection
    // -------------------------------------------------------------------------
    logic sck_rise;
    logic sck_fall;
    logic cs_fall;
    logic cs_rise;
    logic in_frame;
    logic bit_rise;
    logic bit_fall;
    logic byte_done;

    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [6:0] rx_sr_q,   rx_sr_d;
    logic [7:0] tx_sr_q,   tx_sr_d;
    logic [7:0] rx_next;

    assign sck_rise = sck_s & ~sck_prev_q;
    assign sck_fall = ~sck_s & sck_prev_q;
    assign cs_fall  = ~cs_s & cs_prev_q & sync_vld_q[SYNC_STAGES];
    assign cs_rise  = cs_s & ~cs_prev_q;

    // The bit engine is frozen in IDLE; this also keeps a CS_N that was held
    // low across reset from clocking bits into a frame that never started.
    assign in_frame  = (state_q != ST_IDLE);
    assign bit_rise  = sck_rise & in_frame;
    assign bit_fall  = sck_fall & in_frame;

    // Byte as it will look after the current rise has shifted in MOSI.
    assign rx_next   = {rx_sr_q, mosi_s};
    assign byte_done = bit_rise & (bit_cnt_q == 3'd7);

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d = ST_CMD;
                end
            end
            ST_CMD: begin
                if (byte_done) begin
                    state_d = rx_next[7] ? ST_RD_ISSUE : ST_WDATA;
                end
            end
            ST_WDATA: begin
                state_d = ST_WDATA;
            end
            ST_RD_ISSUE: begin
                state_d = ST_RD_LOAD;
            end
            ST_RD_LOAD: begin
                state_d = ST_RDATA;
            end
            ST_RDATA: begin
                if (byte_done) begin
                    state_d = ST_RD_ISSUE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // CS deassertion ends the frame from any state. A coincident
        // byte_done still has its datapath effect below; only the follow-on
        // state (e.g. a read prefetch) is abandoned.
        if (cs_rise) begin
            state_d = ST_IDLE;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    logic [ADDR_W-1:0] reg_addr_q,  reg_addr_d;
    logic [7:0]        reg_wdata_q, reg_wdata_d;
    logic              reg_wr_q,    reg_wr_d;
    logic              frame_err_q, frame_err_d;

    always_comb begin
        reg_rd    = (state_q == ST_RD_ISSUE);
        reg_wr    = reg_wr_q;
        reg_addr  = reg_addr_q;
        reg_wdata = reg_wdata_q;
        frame_err = frame_err_q;
        miso      = tx_sr_q[7];
        busy      = ~cs_s;
        miso_oe   = ~cs_s;
    end

    // -------------------------------------------------------------------------
    // Datapath: shift registers, bit counter, address and strobes
    // -------------------------------------------------------------------------
    always_comb begin
        bit_cnt_d   = bit_cnt_q;
        rx_sr_d     = rx_sr_q;
        tx_sr_d     = tx_sr_q;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        reg_wr_d    = 1'b0;
        frame_err_d = 1'b0;

        if (state_q == ST_IDLE) begin
            bit_cnt_d = 3'd0;
            rx_sr_d   = 7'd0;
            tx_sr_d   = 8'd0;
        end else begin
            if (bit_rise) begin
                rx_sr_d   = rx_next[6:0];
                bit_cnt_d = bit_cnt_q + 3'd1;
            end

            // Only falls inside a byte advance miso. The fall that follows a
            // byte's last rise must leave the freshly loaded read byte alone,
            // so its MSB is still on miso at the first rise of the next byte.
            if (bit_fall && (bit_cnt_q != 3'd0)) begin
                tx_sr_d = {tx_sr_q[6:0], 1'b0};
            end

            if (state_q == ST_RD_LOAD) begin
                tx_sr_d = reg_rdata;
            end

            if (byte_done) begin
                case (state_q)
                    ST_CMD: begin
                        reg_addr_d = rx_next[ADDR_W-1:0];
                    end
                    ST_WDATA: begin
                        reg_wdata_d = rx_next;
                        reg_wr_d    = 1'b1;
                    end
                    ST_RDATA: begin
                        reg_addr_d = reg_addr_q + ADDR_W'(1);
                    end
                    default: begin
                    end
                endcase
            end

            // End of frame: discard any partial byte. byte_done leaves
            // bit_cnt_q at 7, so it is excluded explicitly from the error.
            if (cs_rise) begin
                bit_cnt_d = 3'd0;
                if (!byte_done && (bit_cnt_q != 3'd0)) begin
                    frame_err_d = 1'b1;
                end
            end
        end

        // Write address advances the clk after the strobe so the bank sees
        // the strobe with the address it was written for.
        if (reg_wr_q) begin
            reg_addr_d = reg_addr_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_q   <= 3'd0;
            rx_sr_q     <= 7'd0;
            tx_sr_q     <= 8'd0;
            reg_addr_q  <= '0;
            reg_wdata_q <= 8'd0;
            reg_wr_q    <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            bit_cnt_q   <= bit_cnt_d;
            rx_sr_q     <= rx_sr_d;
            tx_sr_q     <= tx_sr_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            reg_wr_q    <= reg_wr_d;
            frame_err_q <= frame_err_d;
        end
    end

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// -----------------------------------------------------------------------------
// tb_spi_slave_ctrl
//
// Drives SPI mode-0 frames into spi_slave_ctrl. For every frame the expected
// register-port events and MISO bytes are computed from the frame contents
// and a shadow copy of the register bank, then queued; a monitor process pops
// and compares whenever the DUT strobes the port or a MISO byte completes.
// -----------------------------------------------------------------------------
module tb_spi_slave_ctrl;

    localparam int HALF = 8;   // SCK half period in clk cycles

    localparam logic [1:0] EV_WR  = 2'd0;
    localparam logic [1:0] EV_RD  = 2'd1;
    localparam logic [1:0] EV_ERR = 2'd2;

    typedef struct packed {
        logic [1:0] kind;
        logic [6:0] addr;
        logic [7:0] data;
    } ev_t;

    logic       clk;
    logic       rst_n;
    logic       sck;
    logic       cs_n;
    logic       mosi;
    logic       miso;
    logic       miso_oe;
    logic [6:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_wr;
    logic       reg_rd;
    logic [7:0] reg_rdata;
    logic       busy;
    logic       frame_err;

    int cmp_cnt = 0;
    int err_cnt = 0;

    ev_t        exp_q[$];
    logic [7:0] miso_q[$];
    logic [7:0] fdat[$];
    logic [7:0] shadow[128];
    logic [7:0] bank[128];
    logic       init_bank;
    logic       miso_mon_en;

    spi_slave_ctrl #(
        .ADDR_W      (7),
        .SYNC_STAGES (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sck       (sck),
        .cs_n      (cs_n),
        .mosi      (mosi),
        .miso      (miso),
        .miso_oe   (miso_oe),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_wr    (reg_wr),
        .reg_rd    (reg_rd),
        .reg_rdata (reg_rdata),
        .busy      (busy),
        .frame_err (frame_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Register bank seen by the DUT: read data valid one clk after reg_rd.
    always @(posedge clk) begin
        if (init_bank) begin
            for (int i = 0; i < 128; i++) begin
                bank[i] <= 8'(i + 8'h40);
            end
            reg_rdata <= 8'd0;
        end else begin
            if (reg_wr) begin
                bank[reg_addr] <= reg_wdata;
            end
            if (reg_rd) begin
                reg_rdata <= bank[reg_addr];
            end
        end
    end

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] req);
        cmp_cnt++;
        if (act !== req) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
        end
    endfunction

    function automatic ev_t mk_ev(input logic [1:0] k, input logic [6:0] a,
                                  input logic [7:0] d);
        ev_t e;
        e.kind = k;
        e.addr = a;
        e.data = d;
        return e;
    endfunction

    function automatic void check_ev(input logic [1:0] kind);
        ev_t e;
        if (exp_q.size() == 0) begin
            cmp_cnt++;
            err_cnt++;
            $display("FAIL sb_unexpected: got strobe kind %0d addr 0x%0h, required none at %0t",
                     kind, reg_addr, $time);
            return;
        end
        e = exp_q.pop_front();
        chk("sb_kind", 32'(kind), 32'(e.kind));
        if (kind != EV_ERR) begin
            chk("sb_addr", 32'(reg_addr), 32'(e.addr));
        end
        if (kind == EV_WR) begin
            chk("sb_wdata", 32'(reg_wdata), 32'(e.data));
        end
    endfunction

    // Monitor: register-port strobes and MISO bytes (sampled at SCK rise).
    initial begin
        int         nbits;
        logic [7:0] sh;
        logic       sck_m;
        nbits = 0;
        sh    = 8'd0;
        sck_m = 1'b0;
        forever begin
            @(negedge clk);
            if (reg_wr || reg_rd || frame_err) begin
                chk("wr_rd_exclusive", 32'(reg_wr & reg_rd), 32'd0);
                if (reg_wr)    check_ev(EV_WR);
                if (reg_rd)    check_ev(EV_RD);
                if (frame_err) check_ev(EV_ERR);
            end
            if (!miso_mon_en || cs_n) begin
                nbits = 0;
            end else if (sck && !sck_m) begin
                sh = {sh[6:0], miso};
                nbits++;
                if (nbits == 8) begin
                    nbits = 0;
                    if (miso_q.size() == 0) begin
                        cmp_cnt++;
                        err_cnt++;
                        $display("FAIL miso_unexpected: got byte 0x%0h, required none", sh);
                    end else begin
                        chk("miso_byte", 32'(sh), 32'(miso_q.pop_front()));
                    end
                end
            end
            sck_m = sck;
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic send_bit(input logic b);
        mosi = b;
        wait_clks(HALF);
        sck = 1'b1;
        wait_clks(HALF);
        sck = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            send_bit(b[i]);
        end
    endtask

    task automatic drain_check();
        chk("drain_events", 32'(exp_q.size()), 32'd0);
        chk("drain_miso", 32'(miso_q.size()), 32'd0);
        exp_q.delete();
        miso_q.delete();
    endtask

    // One frame: command byte, fdat as full data bytes, then pbits stray bits.
    task automatic run_frame(input logic [7:0] cmd, input int pbits);
        logic [6:0] a;
        int         n;
        a = cmd[6:0];
        n = fdat.size();

        // Reference model for this frame.
        miso_q.push_back(8'h00);
        if (!cmd[7]) begin
            for (int i = 0; i < n; i++) begin
                exp_q.push_back(mk_ev(EV_WR, a + 7'(i), fdat[i]));
                shadow[a + 7'(i)] = fdat[i];
                miso_q.push_back(8'h00);
            end
        end else begin
            for (int i = 0; i <= n; i++) begin
                exp_q.push_back(mk_ev(EV_RD, a + 7'(i), 8'h00));
            end
            for (int i = 0; i < n; i++) begin
                miso_q.push_back(shadow[a + 7'(i)]);
            end
        end
        if (pbits != 0) begin
            exp_q.push_back(mk_ev(EV_ERR, 7'd0, 8'h00));
        end

        $display("frame cmd=0x%02h data_bytes=%0d partial_bits=%0d", cmd, n, pbits);

        cs_n = 1'b0;
        wait_clks(10);
        chk("busy_active", 32'(busy), 32'd1);
        chk("miso_oe_active", 32'(miso_oe), 32'd1);
        send_byte(cmd);
        for (int i = 0; i < n; i++) begin
            send_byte(fdat[i]);
        end
        for (int i = 0; i < pbits; i++) begin
            send_bit(1'($urandom_range(0, 1)));
        end
        wait_clks(HALF);
        cs_n = 1'b1;
        wait_clks(30);
        chk("busy_idle", 32'(busy), 32'd0);
        chk("miso_oe_idle", 32'(miso_oe), 32'd0);
        drain_check();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_miso"},      32'(miso),      32'd0);
        chk({tag, "_miso_oe"},   32'(miso_oe),   32'd0);
        chk({tag, "_reg_addr"},  32'(reg_addr),  32'd0);
        chk({tag, "_reg_wdata"}, 32'(reg_wdata), 32'd0);
        chk({tag, "_reg_wr"},    32'(reg_wr),    32'd0);
        chk({tag, "_reg_rd"},    32'(reg_rd),    32'd0);
        chk({tag, "_busy"},      32'(busy),      32'd0);
        chk({tag, "_frame_err"}, 32'(frame_err), 32'd0);
    endtask

    initial begin
        rst_n       = 1'b0;
        sck         = 1'b0;
        cs_n        = 1'b1;
        mosi        = 1'b0;
        miso_mon_en = 1'b1;
        init_bank   = 1'b1;
        for (int i = 0; i < 128; i++) begin
            shadow[i] = 8'(i + 8'h40);
        end

        wait_clks(3);
        check_reset_outputs("por");
        init_bank = 1'b0;
        rst_n     = 1'b1;
        wait_clks(10);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_miso_oe", 32'(miso_oe), 32'd0);

        // Single write.
        fdat = '{8'hA5};
        run_frame(8'h05, 0);

        // Burst write wrapping 0x7F -> 0x00.
        fdat = '{8'h11, 8'h22, 8'h33};
        run_frame(8'h7E, 0);

        // Burst read of 0x03, 0x04 plus prefetch of 0x05.
        fdat = '{8'h5A, 8'hC3};
        run_frame(8'h83, 0);

        // Abort mid-byte, then a clean write to the same address.
        fdat.delete();
        run_frame(8'h10, 5);
        fdat = '{8'h99};
        run_frame(8'h10, 0);

        // Reset in the middle of data byte 1; CS_N held low across release.
        $display("frame reset mid-byte");
        miso_mon_en = 1'b0;
        cs_n = 1'b0;
        wait_clks(10);
        send_byte(8'h10);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        wait_clks(4);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        wait_clks(3);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send_bit(1'b1);
        end
        send_byte(8'hA5);
        chk("postrst_busy", 32'(busy), 32'd1);
        wait_clks(HALF);
        cs_n = 1'b1;
        wait_clks(30);
        drain_check();
        miso_mon_en = 1'b1;

        // Command-only read frame.
        fdat.delete();
        run_frame(8'h84, 0);

        // Randomized frames.
        for (int f = 0; f < 24; f++) begin
            int nd;
            int pb;
            fdat.delete();
            nd = int'($urandom_range(0, 3));
            for (int i = 0; i < nd; i++) begin
                fdat.push_back(8'($urandom));
            end
            pb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0;
            run_frame(8'($urandom), pb);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
